// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator side of the mux/ALU operand interface. Commands are queued in a
// small in-order FIFO. Each command is driven onto the combinational mux/ALU
// datapath (dp_*), held for SETTLE_CYCLES cycles, and then dp_result is
// sampled. Every result is returned in order on a valid/ready response port,
// tagged with a wrapping issue index.
//
// Optional feature: define RESULT_CHECK_EN to add an internal result checker
// and the sticky chk_err output. Without it, that port and its logic are absent.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_ready = FIFO not full
//   cmd_op[1:0]               {x, sel}: 0x -> a|b, 10 -> a&b, 11 -> pass a
//   cmd_a, cmd_b [7:0]        operands
//   dp_x, dp_sel, dp_a, dp_b  operands driven onto the datapath
//   dp_result [7:0]           combinational datapath result
//   rsp_valid/rsp_ready       response handshake
//   rsp_data [7:0]            sampled result
//   rsp_tag [TAG_W-1:0]       issue index of this response
//   busy                      FSM not idle or FIFO not empty
//   chk_err                   sticky result-mismatch flag (RESULT_CHECK_EN only)
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic             dp_x,
  output logic             dp_sel,
  output logic [7:0]       dp_a,
  output logic [7:0]       dp_b,
  input  logic [7:0]       dp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef RESULT_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP
  } state_t;

  // FIFO entry layout: {op[1:0], a[7:0], b[7:0]}
  logic [17:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             dp_x_q, dp_x_d;
  logic             dp_sel_q, dp_sel_d;
  logic [7:0]       dp_a_q, dp_a_d;
  logic [7:0]       dp_b_q, dp_b_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             push;
  logic             pop;
  logic             sample;
  logic [17:0]      head;

  // Next-state: FIFO bookkeeping and the IDLE/DRIVE/RESP sequencer
  always_comb begin
    push        = cmd_valid && cmd_ready_q;
    pop         = 1'b0;
    sample      = 1'b0;
    head        = mem_q[rd_ptr_q];
    state_d     = state_q;
    settle_d    = settle_q;
    tag_d       = tag_q;
    dp_x_d      = dp_x_q;
    dp_sel_d    = dp_sel_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_q == 4'd0) begin
          sample      = 1'b1;
          rsp_data_d  = dp_result;
          rsp_tag_d   = tag_q;
          tag_d       = tag_q + TAG_W'(1);
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Chain straight into the next command to avoid an IDLE bubble
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      dp_x_d   = head[17];
      dp_sel_d = head[16];
      dp_a_d   = head[15:8];
      dp_b_d   = head[7:0];
      settle_d = SETTLE_INIT;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Registered from the post-update count, so a pop from a full FIFO only
    // reopens cmd_ready on the following cycle.
    cmd_ready_d = (count_d != DEPTH_C);
  end

  // Stage boundary: control and datapath-facing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      state_q     <= S_IDLE;
      settle_q    <= '0;
      tag_q       <= '0;
      dp_x_q      <= 1'b0;
      dp_sel_q    <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      tag_q       <= tag_d;
      dp_x_q      <= dp_x_d;
      dp_sel_q    <= dp_sel_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  // Stage boundary: FIFO storage (pointers reset, contents need not)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end
  end

`ifdef RESULT_CHECK_EN
  function automatic logic [7:0] expected_result(input logic x, input logic sel,
                                                 input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    if (!x)       r = a | b;
    else if (!sel) r = a & b;
    else          r = a;
    return r;
  endfunction

  logic chk_err_q, chk_err_d;

  // Compared on the edge that enters RESP, against the same dp_result value
  // that is captured into rsp_data.
  always_comb begin
    chk_err_d = chk_err_q;
    if (sample && (dp_result != expected_result(dp_x_q, dp_sel_q, dp_a_q, dp_b_q))) begin
      chk_err_d = 1'b1;
    end
  end

  // Stage boundary: sticky checker flag
  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign dp_x      = dp_x_q;
  assign dp_sel    = dp_sel_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_op_sequencer. Provides the combinational mux/ALU datapath,
// drives directed and randomized traffic, and keeps a queue-based model of the
// outstanding commands (expected result, operands, tag) that the response
// stream is compared against every cycle.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [7:0]    cmd_a = 8'h00;
  logic [7:0]    cmd_b = 8'h00;
  logic          dp_x;
  logic          dp_sel;
  logic [7:0]    dp_a;
  logic [7:0]    dp_b;
  logic [7:0]    dp_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          busy;
`ifdef RESULT_CHECK_EN
  logic          chk_err;
`endif
  logic          bad_mode = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .TAG_W        (TW),
    .SETTLE_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .dp_x     (dp_x),
    .dp_sel   (dp_sel),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag),
    .busy     (busy)
`ifdef RESULT_CHECK_EN
    ,
    .chk_err  (chk_err)
`endif
  );

  // Reference mux/ALU behaviour
  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    if (!op[1])     return a | b;
    else if (!op[0]) return a & b;
    else            return a;
  endfunction

  assign dp_result = bad_mode ? 8'h00 : alu_ref({dp_x, dp_sel}, dp_a, dp_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: every accepted command waits in q until its response is accepted.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]    op;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [7:0]    data;
    logic [TW-1:0] tag;
  } ent_t;

  ent_t          q[$];
  logic [TW-1:0] next_tag = '0;
  bit            live = 1'b0;
  bit            after_rst = 1'b0;
  bit            hold_prev = 1'b0;
  logic [7:0]    hold_data;
  logic [TW-1:0] hold_tag;
  int            rsp_seen = 0;
  logic [7:0]    last_data = 8'h00;
  logic [TW-1:0] last_tag = '0;

  always @(negedge clk) begin
    if (live) begin
      if (after_rst) begin
        chk("reset_ctrl", 32'({cmd_ready, rsp_valid, busy, dp_x, dp_sel, rsp_tag}), 32'(0));
        chk("reset_data", 32'({dp_a, dp_b, rsp_data}), 32'(0));
`ifdef RESULT_CHECK_EN
        chk("reset_chk_err", 32'(chk_err), 32'(0));
`endif
      end else begin
        if (q.size() < DEPTH) chk("cmd_ready_free", 32'(cmd_ready), 32'(1));
        else if (q.size() == DEPTH + 1) chk("cmd_ready_full", 32'(cmd_ready), 32'(0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (hold_prev) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'(1));
          chk("rsp_hold_data", 32'(rsp_data), 32'(hold_data));
          chk("rsp_hold_tag", 32'(rsp_tag), 32'(hold_tag));
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("rsp_without_cmd_outstanding", 32'(q.size()), 32'(1));
          end else begin
            chk("dp_op", 32'({dp_x, dp_sel}), 32'(q[0].op));
            chk("dp_a", 32'(dp_a), 32'(q[0].a));
            chk("dp_b", 32'(dp_b), 32'(q[0].b));
            if (rsp_ready) begin
              chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
              chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
              rsp_seen++;
              last_data = rsp_data;
              last_tag  = rsp_tag;
              void'(q.pop_front());
            end
          end
        end
      end
    end
    // Advance the model across the coming rising edge
    if (rst) begin
      q.delete();
      next_tag  = '0;
      live      = 1'b1;
      after_rst = 1'b1;
      hold_prev = 1'b0;
    end else if (live) begin
      after_rst = 1'b0;
      hold_prev = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_tag  = rsp_tag;
      if (cmd_valid && cmd_ready) begin
        q.push_back('{cmd_op, cmd_a, cmd_b,
                      bad_mode ? 8'h00 : alu_ref(cmd_op, cmd_a, cmd_b), next_tag});
        next_tag = next_tag + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) chk("push_accept_timeout", 32'(ok), 32'(1));
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) tick();
    chk("wait_idle", 32'(busy), 32'(0));
  endtask

  task automatic wait_rsp(input int max_cycles);
    for (int i = 0; i < max_cycles && !rsp_valid; i++) tick();
    chk("wait_rsp", 32'(rsp_valid), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset held for 3 cycles, then released
    repeat (3) tick();
    chk("t1_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("t1_rst_busy", 32'(busy), 32'(0));
    chk("t1_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    rst = 1'b0;
    tick();
    chk("t1_cmd_ready_after_release", 32'(cmd_ready), 32'(1));
    chk("t1_busy_after_release", 32'(busy), 32'(0));

    // Single OR command: latency and value
    rsp_ready = 1'b1;
    push(2'b00, 8'h0F, 8'hF0);          // pushed at E0
    tick();                             // E1
    chk("t2_dp_x", 32'(dp_x), 32'(0));
    chk("t2_dp_a", 32'(dp_a), 32'(8'h0F));
    chk("t2_dp_b", 32'(dp_b), 32'(8'hF0));
    chk("t2_no_rsp_yet", 32'(rsp_valid), 32'(0));
    tick();                             // E2
    chk("t2_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("t2_rsp_data", 32'(rsp_data), 32'(8'hFF));
    chk("t2_rsp_tag", 32'(rsp_tag), 32'(0));
    tick();                             // E3 handshake
    chk("t2_rsp_done", 32'(rsp_valid), 32'(0));
    chk("t2_idle", 32'(busy), 32'(0));

    // Back-pressure: one in flight plus a full FIFO
    do_reset(2);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'(i), 8'(8'h10 + i), 8'(8'hC3 ^ i));
    chk("t3_full", 32'(cmd_ready), 32'(0));
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_still_full", 32'(cmd_ready), 32'(0));
    end
    cmd_valid = 1'b0;
    chk("t3_first_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("t3_first_rsp_tag", 32'(rsp_tag), 32'(0));
    chk("t3_first_rsp_data", 32'(rsp_data), 32'(8'h10 | 8'hC3));
    base = rsp_seen;
    rsp_ready = 1'b1;
    wait_idle(60);
    chk("t3_rsp_count", 32'(rsp_seen - base), 32'(5));
    chk("t3_last_tag", 32'(last_tag), 32'(4));

    // Pass-a with tag wrap
    do_reset(1);
    rsp_ready = 1'b1;
    base = rsp_seen;
    for (int i = 0; i < 18; i++) push(2'b11, 8'(i), 8'($urandom));
    wait_idle(60);
    chk("t4_rsp_count", 32'(rsp_seen - base), 32'(18));
    chk("t4_last_tag_wrapped", 32'(last_tag), 32'(1));
    chk("t4_last_data", 32'(last_data), 32'(17));

    // Reset while DRIVE with two commands still queued
    do_reset(1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(2'b10, 8'hF0, 8'(8'h3C + i));
    chk("t5_in_resp", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    tick();                             // handshake, next command enters DRIVE
    rsp_ready = 1'b0;
    chk("t5_drive_no_rsp", 32'(rsp_valid), 32'(0));
    chk("t5_drive_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    tick();
    chk("t5_fifo_empty_busy", 32'(busy), 32'(0));
    chk("t5_ready_again", 32'(cmd_ready), 32'(1));
    rsp_ready = 1'b1;
    push(2'b00, 8'h01, 8'h02);
    wait_rsp(10);
    chk("t5_tag_restart", 32'(rsp_tag), 32'(0));
    chk("t5_data", 32'(rsp_data), 32'(8'h03));
    wait_idle(10);

`ifdef RESULT_CHECK_EN
    // Corrupted datapath result trips the sticky checker
    do_reset(1);
    chk("t6_chk_err_clear", 32'(chk_err), 32'(0));
    bad_mode  = 1'b1;
    rsp_ready = 1'b1;
    push(2'b10, 8'hAA, 8'hAA);
    wait_rsp(10);
    chk("t6_delivered_unchanged", 32'(rsp_data), 32'(8'h00));
    chk("t6_chk_err_set", 32'(chk_err), 32'(1));
    tick();
    bad_mode = 1'b0;
    for (int i = 0; i < 3; i++) push(2'(i), 8'($urandom), 8'($urandom));
    wait_idle(30);
    chk("t6_chk_err_sticky", 32'(chk_err), 32'(1));
    do_reset(1);
    chk("t6_chk_err_reset", 32'(chk_err), 32'(0));
`endif

    // Randomized traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      rsp_ready = (i % 500 < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    wait_idle(100);
    chk("drain_model_empty", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
